// File: rtl/ws2812_rx.sv
// WS2812 serial-line receiver: decodes pulse-width-coded bits into 24-bit words,
// tracks word position within a frame and flags glitches, errors and overflow.
`timescale 1ns/1ps

module ws2812_rx #(
  parameter int NUM_LEDS     = 8,
  parameter int THRESH_CYC   = 8,
  parameter int MIN_HIGH_CYC = 2,
  parameter int MAX_HIGH_CYC = 20,
  parameter int RESET_CYC    = 600
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_in,
  output logic [23:0] word,
  output logic [7:0]  word_idx,
  output logic        word_valid,
  output logic        frame_end,
  output logic        err,
  output logic        overflow
);

  localparam int HW = $clog2(MAX_HIGH_CYC + 1);
  localparam int LW = $clog2(RESET_CYC + 1);

  localparam logic [HW-1:0] HI_MAX_M1 = HW'(MAX_HIGH_CYC - 1);
  localparam logic [HW-1:0] HI_MIN    = HW'(MIN_HIGH_CYC);
  localparam logic [HW-1:0] HI_THR    = HW'(THRESH_CYC);
  localparam logic [LW-1:0] LO_RST_M1 = LW'(RESET_CYC - 1);
  localparam logic [7:0]    NLEDS     = 8'(NUM_LEDS);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, ds_q, ds_prev_q;
  logic [HW-1:0] hi_cnt_q, hi_cnt_d;
  logic [LW-1:0] lo_cnt_q, lo_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    word_cnt_q, word_cnt_d;
  logic [23:0]   shift_q, shift_d;
  logic [23:0]   word_q, word_d;
  logic [7:0]    word_idx_q, word_idx_d;
  logic          word_valid_q, word_valid_d;
  logic          frame_end_q, frame_end_d;
  logic          err_q, err_d;
  logic          overflow_q, overflow_d;
  logic          frame_ovf_q, frame_ovf_d;
  logic          rise, bit_val;
  logic [23:0]   shift_next;

  assign rise       = ds_q & ~ds_prev_q;
  assign bit_val    = (hi_cnt_q >= HI_THR);
  assign shift_next = {shift_q[22:0], bit_val};

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_idx_d   = word_idx_q;
    word_valid_d = 1'b0;
    frame_end_d  = 1'b0;
    err_d        = 1'b0;
    overflow_d   = overflow_q;
    frame_ovf_d  = frame_ovf_q;

    unique case (state_q)
      // Wait for a full reset gap before trusting the line; the gap opens a fresh frame.
      S_SYNC: begin
        if (ds_q) begin
          lo_cnt_d = '0;
        end else if (lo_cnt_q >= LO_RST_M1) begin
          state_d     = S_IDLE;
          lo_cnt_d    = '0;
          bit_cnt_d   = '0;
          shift_d     = '0;
          word_cnt_d  = '0;
          frame_ovf_d = 1'b0;
        end else begin
          lo_cnt_d = lo_cnt_q + 1'b1;
        end
      end

      S_IDLE: begin
        if (rise) begin
          state_d  = S_HIGH;
          hi_cnt_d = HW'(1);
        end
      end

      S_HIGH: begin
        if (ds_q) begin
          if (hi_cnt_q >= HI_MAX_M1) begin
            err_d     = 1'b1;
            shift_d   = '0;
            bit_cnt_d = '0;
            lo_cnt_d  = '0;
            state_d   = S_SYNC;
          end else begin
            hi_cnt_d = hi_cnt_q + 1'b1;
          end
        end else if (hi_cnt_q < HI_MIN) begin
          // Glitch: resume the interrupted low period as if nothing happened.
          state_d = S_LOW;
        end else begin
          state_d  = S_LOW;
          lo_cnt_d = LW'(1);
          shift_d  = shift_next;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            if (word_cnt_q < NLEDS) begin
              word_d       = shift_next;
              word_idx_d   = word_cnt_q;
              word_valid_d = 1'b1;
              word_cnt_d   = word_cnt_q + 1'b1;
            end else begin
              overflow_d  = 1'b1;
              frame_ovf_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      S_LOW: begin
        if (rise) begin
          state_d  = S_HIGH;
          hi_cnt_d = HW'(1);
        end else if (lo_cnt_q >= LO_RST_M1) begin
          frame_end_d = 1'b1;
          err_d       = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          shift_d     = '0;
          word_cnt_d  = '0;
          lo_cnt_d    = '0;
          state_d     = S_IDLE;
          // Overflow survives the frame that caused it and clears after a clean one.
          if (!frame_ovf_q) overflow_d = 1'b0;
          frame_ovf_d = 1'b0;
        end else begin
          lo_cnt_d = lo_cnt_q + 1'b1;
        end
      end

      default: state_d = S_SYNC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_SYNC;
      sync1_q      <= 1'b0;
      ds_q         <= 1'b0;
      ds_prev_q    <= 1'b0;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_idx_q   <= '0;
      word_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      err_q        <= 1'b0;
      overflow_q   <= 1'b0;
      frame_ovf_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= data_in;
      ds_q         <= sync1_q;
      ds_prev_q    <= ds_q;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_idx_q   <= word_idx_d;
      word_valid_q <= word_valid_d;
      frame_end_q  <= frame_end_d;
      err_q        <= err_d;
      overflow_q   <= overflow_d;
      frame_ovf_q  <= frame_ovf_d;
    end
  end

  assign word       = word_q;
  assign word_idx   = word_idx_q;
  assign word_valid = word_valid_q;
  assign frame_end  = frame_end_q;
  assign err        = err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: stimulus pushes expected events, a monitor
// pops and compares them whenever the receiver strobes an output.
`timescale 1ns/1ps

module tb_ws2812_rx;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_in;
  logic [23:0] word;
  logic [7:0]  word_idx;
  logic        word_valid, frame_end, err, overflow;

  int checks = 0;
  int errors = 0;

  typedef enum int {EV_WORD = 0, EV_FEND = 1, EV_ERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [23:0] word;
    logic [7:0]  idx;
    logic        err;
  } ev_t;

  ev_t sb[$];
  ev_t mon_ev;

  ws2812_rx dut (
    .clk        (clk),
    .resetn     (resetn),
    .data_in    (data_in),
    .word       (word),
    .word_idx   (word_idx),
    .word_valid (word_valid),
    .frame_end  (frame_end),
    .err        (err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: strobe with empty scoreboard at %0t", name, $time);
  endtask

  task automatic push_word(input logic [23:0] w, input logic [7:0] i);
    ev_t e;
    e.kind = EV_WORD; e.word = w; e.idx = i; e.err = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_fend(input logic e_err);
    ev_t e;
    e.kind = EV_FEND; e.word = '0; e.idx = '0; e.err = e_err;
    sb.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.kind = EV_ERR; e.word = '0; e.idx = '0; e.err = 1'b1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    data_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One 15-cycle bit; optional 1-cycle high glitch inside its low period.
  task automatic send_bit(input logic b, input bit glitch);
    int high;
    high = b ? 10 : 5;
    data_in = 1'b1;
    repeat (high) @(negedge clk);
    data_in = 1'b0;
    if (glitch) begin
      repeat (3) @(negedge clk);
      data_in = 1'b1;
      @(negedge clk);
      data_in = 1'b0;
      repeat (15 - high - 4) @(negedge clk);
    end else begin
      repeat (15 - high) @(negedge clk);
    end
  endtask

  task automatic send_bits(input logic [23:0] w, input int n, input int glitch_bit);
    for (int i = 0; i < n; i++) send_bit(w[23 - i], i == glitch_bit);
  endtask

  task automatic send_word(input logic [23:0] w);
    send_bits(w, 24, -1);
  endtask

  // Monitor: compares every strobe against the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn) begin
      if (word_valid) begin
        if (sb.size() == 0) unexpected("word_valid");
        else begin
          mon_ev = sb.pop_front();
          check("word_kind", 32'(EV_WORD), 32'(mon_ev.kind));
          check("word", 32'(word), 32'(mon_ev.word));
          check("word_idx", 32'(word_idx), 32'(mon_ev.idx));
        end
      end
      if (frame_end) begin
        if (sb.size() == 0) unexpected("frame_end");
        else begin
          mon_ev = sb.pop_front();
          check("fend_kind", 32'(EV_FEND), 32'(mon_ev.kind));
          check("fend_err", 32'(err), 32'(mon_ev.err));
        end
      end else if (err) begin
        if (sb.size() == 0) unexpected("err");
        else begin
          mon_ev = sb.pop_front();
          check("err_kind", 32'(EV_ERR), 32'(mon_ev.kind));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn  = 1'b0;
    data_in = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_word", 32'(word), 32'h0);
    check("rst_word_idx", 32'(word_idx), 32'h0);
    check("rst_word_valid", 32'(word_valid), 32'h0);
    check("rst_frame_end", 32'(frame_end), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    resetn = 1'b1;

    // Initial sync gap (silent), then a single-word frame.
    idle(610);
    push_word(24'h00FF00, 8'd0);
    push_fend(1'b0);
    send_word(24'h00FF00);
    idle(620);
    check("ovf_after_basic", 32'(overflow), 32'h0);

    // Nine words into an eight-word frame.
    for (int i = 0; i < 8; i++) push_word({8'(i), 8'hA0 ^ 8'(i), 8'(i * 17)}, 8'(i));
    push_fend(1'b0);
    for (int i = 0; i < 9; i++) send_word({8'(i), 8'hA0 ^ 8'(i), 8'(i * 17)});
    idle(30);
    check("ovf_set", 32'(overflow), 32'h1);
    idle(590);
    check("ovf_held_frame_end", 32'(overflow), 32'h1);
    push_word(24'h5A5A5A, 8'd0);
    push_fend(1'b0);
    send_word(24'h5A5A5A);
    idle(620);
    check("ovf_cleared", 32'(overflow), 32'h0);

    // Glitch in the low period of bit 5.
    push_word(24'hA5A5A5, 8'd0);
    push_fend(1'b0);
    send_bits(24'hA5A5A5, 24, 5);
    idle(620);

    // Stuck-high line mid-word, then resync and a clean frame.
    push_err();
    send_bits(24'hFFFFFF, 7, -1);
    data_in = 1'b1;
    repeat (25) @(negedge clk);
    idle(610);
    push_word(24'h123456, 8'd0);
    push_fend(1'b0);
    send_word(24'h123456);
    idle(620);

    // Partial word before a reset gap.
    push_fend(1'b1);
    send_bits(24'hF0F0F0, 10, -1);
    idle(620);

    // Reset during bit 12 while the line keeps toggling.
    send_bits(24'hC3C3C3, 12, -1);
    data_in = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_word", 32'(word), 32'h0);
    check("midrst_word_valid", 32'(word_valid), 32'h0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    data_in = 1'b0;
    repeat (5) @(negedge clk);
    send_bits(24'hC3C3C3, 11, -1);
    send_word(24'h3C3C3C);
    idle(610);
    push_word(24'h9ABCDE, 8'd0);
    push_fend(1'b0);
    send_word(24'h9ABCDE);
    idle(620);

    idle(20);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter NUM_LEDS, default 8, sets the number of words accepted per frame (1..255).
REQ-002 Parameter THRESH_CYC, default 8: high time in clk cycles at or above which a bit decodes as 1.
REQ-003 Parameter MIN_HIGH_CYC, default 2: high pulses shorter than this are glitches.
REQ-004 Parameter MAX_HIGH_CYC, default 20: high pulses this long or longer are errors.
REQ-005 Parameter RESET_CYC, default 600: low time in clk cycles that constitutes a latch/reset gap.
REQ-006 Port clk, input, 1: sole clock; one clock domain, all logic on posedge clk.
REQ-007 Port resetn, input, 1: reset is asynchronous and active-low.
REQ-008 Port data_in, input, 1: asynchronous WS2812 serial line.
REQ-009 Port word, output, 24: last decoded word, first-received bit in bit 23.
REQ-010 Port word_idx, output, 8: index of word within the current frame, 0-based.
REQ-011 Port word_valid, output, 1: one-cycle strobe; word and word_idx valid while high.
REQ-012 Port frame_end, output, 1: one-cycle strobe on a detected reset gap.
REQ-013 Port err, output, 1: one-cycle strobe on any decode error.
REQ-014 Port overflow, output, 1: sticky flag; more than NUM_LEDS words in one frame.

Function
REQ-015 data_in SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized signal (ds) and its previous value.
REQ-016 FSM states: SYNC, IDLE, HIGH, LOW.
REQ-017 SYNC: entered at reset; ignores pulses; counts consecutive low cycles of ds; at RESET_CYC -> IDLE without pulsing frame_end; any high restarts the count.
REQ-018 IDLE: on ds rising edge -> HIGH, high counter loaded with 1.
REQ-019 HIGH: high counter increments per cycle while ds high, saturating at MAX_HIGH_CYC.
REQ-020 On ds falling edge in HIGH with count < MIN_HIGH_CYC: no bit, no err, -> LOW with the low counter continuing from its value before the pulse.
REQ-021 On falling edge with MIN_HIGH_CYC <= count < MAX_HIGH_CYC: bit = (count >= THRESH_CYC), shifted into the 24-bit shift register LSB side, bit counter +1, -> LOW with low counter = 1.
REQ-022 When count reaches MAX_HIGH_CYC in HIGH: err strobes once, partial word and bit counter cleared, -> SYNC.
REQ-023 LOW: low counter increments while ds low, saturating at RESET_CYC; rising edge -> HIGH.
REQ-024 Bit counter reaching 24 SHALL, in the cycle after the falling edge that completed it, drive word = shift register, word_idx = frame word count, word_valid = 1 (if word count < NUM_LEDS), clear the bit counter, and increment the word count.
REQ-025 24th bit with word count already = NUM_LEDS: no word_valid; overflow set; word is dropped.
REQ-026 Low counter reaching RESET_CYC in LOW: frame_end strobes once; word count and bit counter cleared; -> IDLE.
REQ-027 Reset gap with bit counter nonzero: err strobes in the same cycle as frame_end; partial bits discarded.
REQ-028 overflow SHALL clear only on resetn or on the frame_end of the next frame without overflow.
REQ-029 word and word_idx SHALL hold their values between strobes.
REQ-030 Counter widths SHALL be sized for the largest parameter; no counter wraps.

Reset
REQ-031 resetn low, asynchronously: FSM = SYNC; counters, shift register, synchronizer = 0; word = 0, word_idx = 0, word_valid = 0, frame_end = 0, err = 0, overflow = 0.
REQ-032 Reset release mid-stream: no word_valid until a full RESET_CYC low gap has been seen.

Verification
REQ-033 After 600 low cycles, send 24 bits of 0x00FF00 (T0H = 5, T1H = 10, period 15 cycles), then 600 low cycles -> one word_valid with word = 0x00FF00, word_idx = 0, then one frame_end, err = 0.
REQ-034 Send 9 words back-to-back with NUM_LEDS = 8 -> word_valid for idx 0..7 only, overflow = 1 after the 9th word, and overflow clears after the next clean 1-word frame.
REQ-035 Send a 1-cycle high glitch inside a low period of bit 5 -> decoded word unchanged, err = 0.
REQ-036 Hold data_in high for 25 cycles mid-word -> err strobes once; the next valid frame decodes correctly.
REQ-037 Send 10 bits, then 600 low cycles -> frame_end and err strobe in the same cycle, no word_valid.
REQ-038 Assert resetn low during bit 12, release while the line toggles -> no word_valid until after a 600-cycle low gap; the next frame decodes normally.
